// File: rtl/reg_file_mp_if.sv
// reg_file_mp_if: bundles the write ports, read ports and status outputs
// of the multi-port register file. The master drives addresses, enables
// and write data. The slave (the register file) returns read data, busy
// and the write-conflict pulse.
interface reg_file_mp_if #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int N_RD  = 2,
  parameter int N_WR  = 1
);
  localparam int AW = $clog2(NREGS);

  logic [N_WR-1:0]      we;
  logic [N_WR*AW-1:0]   waddr;
  logic [N_WR*XLEN-1:0] wdata;
  logic [N_RD*AW-1:0]   raddr;
  logic [N_RD*XLEN-1:0] rdata;
  logic                 busy;
  logic                 wr_conflict;

  modport master (
    output we, waddr, wdata, raddr,
    input  rdata, busy, wr_conflict
  );

  modport slave (
    input  we, waddr, wdata, raddr,
    output rdata, busy, wr_conflict
  );
endinterface

// File: rtl/reg_file_mp.sv
// reg_file_mp: parametrised N_RD-read / N_WR-write integer register file.
// x0 is hardwired to zero. Higher-index write ports win on address
// collisions. A reset-driven sweep loads every register, with SP_IDX set
// to SP_INIT and all others cleared. Optional same-cycle write-to-read
// forwarding is compiled in when the macro REG_FILE_BYPASS_EN is defined.
module reg_file_mp #(
  parameter int XLEN    = 32,
  parameter int NREGS   = 32,
  parameter int N_RD    = 2,
  parameter int N_WR    = 1,
  parameter int SP_IDX  = 2,
  parameter int SP_INIT = 128
) (
  input  logic          clk,
  input  logic          rst,
  reg_file_mp_if.slave  bus
);
  localparam int AW = $clog2(NREGS);

  localparam logic [0:0] CLEAR = 1'b0;
  localparam logic [0:0] READY = 1'b1;

  logic [0:0]      state_reg;
  logic [AW-1:0]   idx_reg;
  logic [XLEN-1:0] regs [NREGS];
  logic            wr_conflict_reg;
  logic            wr_conflict_next;
  logic            busy;

  assign busy            = (state_reg == CLEAR);
  assign bus.busy        = busy;
  assign bus.wr_conflict = wr_conflict_reg;

  // Sweep FSM plus array update. Reset only touches control state. Ports
  // are applied in ascending index order so the highest port wins.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg <= CLEAR;
      idx_reg   <= '0;
    end else if (state_reg == CLEAR) begin
      regs[idx_reg] <= (idx_reg == AW'(SP_IDX)) ? XLEN'(SP_INIT) : '0;
      idx_reg       <= idx_reg + 1'b1;
      if (idx_reg == AW'(NREGS - 1)) begin
        state_reg <= READY;
      end
    end else begin
      for (int k = 0; k < N_WR; k++) begin
        if (bus.we[k] && (bus.waddr[k*AW +: AW] != '0)) begin
          regs[bus.waddr[k*AW +: AW]] <= bus.wdata[k*XLEN +: XLEN];
        end
      end
    end
  end

  // Detect two or more enabled ports writing the same nonzero address.
  always_comb begin
    wr_conflict_next = 1'b0;
    for (int a = 0; a < N_WR; a++) begin
      for (int b = a + 1; b < N_WR; b++) begin
        if (bus.we[a] && bus.we[b] &&
            (bus.waddr[a*AW +: AW] == bus.waddr[b*AW +: AW]) &&
            (bus.waddr[a*AW +: AW] != '0)) begin
          wr_conflict_next = 1'b1;
        end
      end
    end
  end

  // One-cycle conflict pulse, only meaningful once the sweep has finished.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_conflict_reg <= 1'b0;
    end else begin
      wr_conflict_reg <= (state_reg == READY) ? wr_conflict_next : 1'b0;
    end
  end

  // Combinational read ports: zero while sweeping and for x0.
  for (genvar gi = 0; gi < N_RD; gi++) begin : g_rd
    logic [AW-1:0]   ra;
    logic [XLEN-1:0] rd_val;

    assign ra = bus.raddr[gi*AW +: AW];

    // Select stored value, optionally overridden by an in-flight write.
    always_comb begin
      rd_val = regs[ra];
`ifdef REG_FILE_BYPASS_EN
      for (int k = 0; k < N_WR; k++) begin
        if (bus.we[k] && (bus.waddr[k*AW +: AW] == ra)) begin
          rd_val = bus.wdata[k*XLEN +: XLEN];
        end
      end
`endif
      if (busy || (ra == '0)) begin
        rd_val = '0;
      end
    end

    assign bus.rdata[gi*XLEN +: XLEN] = rd_val;
  end
endmodule

// File: tb/tb_reg_file_mp.sv
module tb_reg_file_mp;
    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int N_RD  = 2;
    localparam int N_WR  = 2;
    localparam int AW    = 5;

    localparam int K_BUSY = 0;
    localparam int K_CONF = 1;
    localparam int K_RD   = 2;

    typedef struct {
        int          kind;
        int          idx;
        logic [31:0] exp;
        string       name;
    } item_t;

    logic  clk;
    logic  rst;
    item_t sb_q[$];
    int    checks;
    int    failures;

    reg_file_mp_if #(.XLEN(XLEN), .NREGS(NREGS), .N_RD(N_RD), .N_WR(N_WR)) bus ();

    reg_file_mp #(
        .XLEN(XLEN), .NREGS(NREGS), .N_RD(N_RD), .N_WR(N_WR),
        .SP_IDX(2), .SP_INIT(128)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        failures++;
        $display("FAIL watchdog: simulation did not finish in time");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    always @(negedge clk) begin
        item_t       it;
        logic [31:0] act;
        while (sb_q.size() > 0) begin
            it = sb_q.pop_front();
            case (it.kind)
                K_BUSY:  act = {31'd0, bus.busy};
                K_CONF:  act = {31'd0, bus.wr_conflict};
                default: act = bus.rdata[it.idx*XLEN +: XLEN];
            endcase
            checks++;
            if (act !== it.exp) begin
                failures++;
                $display("FAIL %s: got 0x%08h expected 0x%08h", it.name, act, it.exp);
            end else begin
                $display("ok   %s: 0x%08h", it.name, act);
            end
        end
    end

    task automatic check_now(input logic [31:0] act, input logic [31:0] exp,
                             input string name);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%08h", name, act);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_item(input int kind, input int idx, input logic [31:0] exp,
                               input string name);
        item_t it;
        it.kind = kind;
        it.idx  = idx;
        it.exp  = exp;
        it.name = name;
        sb_q.push_back(it);
    endtask

    task automatic set_wr(input int k, input logic en, input int addr, input logic [31:0] data);
        bus.we[k]                 = en;
        bus.waddr[k*AW +: AW]     = AW'(addr);
        bus.wdata[k*XLEN +: XLEN] = data;
    endtask

    task automatic set_rd(input int j, input int addr);
        bus.raddr[j*AW +: AW] = AW'(addr);
    endtask

    task automatic idle_writes();
        set_wr(0, 1'b0, 0, 32'h0);
        set_wr(1, 1'b0, 0, 32'h0);
    endtask

    initial begin
        logic [31:0] exp_bp;
        int          waited;
        checks    = 0;
        failures  = 0;
        rst       = 1'b0;
        bus.we    = '0;
        bus.waddr = '0;
        bus.wdata = '0;
        bus.raddr = '0;

        step();
        set_rd(0, 2);
        set_rd(1, 0);
        #1;
        check_now({31'd0, bus.busy}, 32'd1, "reset_busy_now");
        check_now({31'd0, bus.wr_conflict}, 32'd0, "reset_conflict_now");
        check_now(bus.rdata[0 +: XLEN], 32'd0, "reset_rd0_now");
        expect_item(K_BUSY, 0, 32'd1, "reset_busy");
        expect_item(K_CONF, 0, 32'd0, "reset_conflict");
        expect_item(K_RD, 0, 32'd0, "reset_rd0_x2");
        expect_item(K_RD, 1, 32'd0, "reset_rd1_x0");
        step();
        rst = 1'b1;

        for (int i = 0; i < NREGS; i++) begin
            expect_item(K_BUSY, 0, 32'd1, $sformatf("sweep_busy_%0d", i));
            if (i == 5) expect_item(K_RD, 0, 32'd0, "sweep_rd_masked");
            step();
        end
        waited = 0;
        while (bus.busy === 1'b1 && waited < NREGS) begin
            step();
            waited++;
        end
        check_now({31'd0, bus.busy}, 32'd0, "sweep_wait_not_expired");
        expect_item(K_BUSY, 0, 32'd0, "sweep_done_busy");
        expect_item(K_RD, 0, 32'd128, "sp_x2");
        set_rd(1, 1);
        expect_item(K_RD, 1, 32'd0, "x1_zero");
        step();
        set_rd(0, 31);
        expect_item(K_RD, 0, 32'd0, "x31_zero");

        set_wr(0, 1'b1, 5, 32'hDEADBEEF);
        set_rd(1, 5);
`ifdef REG_FILE_BYPASS_EN
        expect_item(K_RD, 1, 32'hDEADBEEF, "x5_same_cycle");
`else
        expect_item(K_RD, 1, 32'h0, "x5_same_cycle");
`endif
        step();
        idle_writes();
        expect_item(K_RD, 1, 32'hDEADBEEF, "x5_after_write");
        expect_item(K_CONF, 0, 32'd0, "single_write_no_conflict");

        set_wr(0, 1'b1, 0, 32'h1234);
        set_wr(1, 1'b1, 0, 32'h5678);
        set_rd(0, 0);
        expect_item(K_RD, 0, 32'h0, "x0_during_write");
        step();
        idle_writes();
        expect_item(K_RD, 0, 32'h0, "x0_after_write");
        expect_item(K_CONF, 0, 32'd0, "x0_no_conflict");

        set_wr(0, 1'b1, 7, 32'h11);
        set_wr(1, 1'b1, 7, 32'h22);
        step();
        idle_writes();
        set_rd(0, 7);
        expect_item(K_RD, 0, 32'h22, "x7_priority");
        expect_item(K_CONF, 0, 32'd1, "conflict_pulse");
        step();
        expect_item(K_CONF, 0, 32'd0, "conflict_one_cycle");

        set_wr(0, 1'b1, 8, 32'h88);
        set_wr(1, 1'b1, 10, 32'hAA);
        step();
        idle_writes();
        set_rd(0, 8);
        set_rd(1, 10);
        expect_item(K_RD, 0, 32'h88, "x8_port0");
        expect_item(K_RD, 1, 32'hAA, "x10_port1");
        expect_item(K_CONF, 0, 32'd0, "distinct_no_conflict");

        set_wr(0, 1'b1, 8, 32'h99);
        set_wr(1, 1'b0, 8, 32'hFF);
        step();
        idle_writes();
        expect_item(K_RD, 0, 32'h99, "x8_disabled_peer");
        expect_item(K_CONF, 0, 32'd0, "disabled_no_conflict");

        set_wr(0, 1'b1, 9, 32'h5);
        step();
        set_wr(0, 1'b1, 9, 32'hA5A5A5A5);
        set_rd(0, 9);
`ifdef REG_FILE_BYPASS_EN
        exp_bp = 32'hA5A5A5A5;
`else
        exp_bp = 32'h5;
`endif
        expect_item(K_RD, 0, exp_bp, "x9_bypass");
        step();
        idle_writes();
        expect_item(K_RD, 0, 32'hA5A5A5A5, "x9_stored");

        rst = 1'b0;
        step();
        rst = 1'b1;
        for (int i = 0; i < 10; i++) step();
        expect_item(K_BUSY, 0, 32'd1, "midsweep_busy");
        rst = 1'b0;
        step();
        rst = 1'b1;
        set_wr(0, 1'b1, 3, 32'hFFFF);
        set_wr(1, 1'b1, 4, 32'hEEEE);
        set_rd(0, 3);
        for (int i = 0; i < NREGS; i++) begin
            if (i == 0 || i == NREGS - 1) begin
                expect_item(K_BUSY, 0, 32'd1, $sformatf("resweep_busy_%0d", i));
                expect_item(K_RD, 0, 32'd0, $sformatf("resweep_rd_masked_%0d", i));
            end
            if (i == NREGS - 1) idle_writes();
            step();
        end
        set_rd(1, 5);
        expect_item(K_BUSY, 0, 32'd0, "resweep_done_busy");
        expect_item(K_RD, 0, 32'd0, "x3_write_discarded");
        expect_item(K_RD, 1, 32'd0, "x5_reinitialised");
        step();
        set_rd(0, 4);
        set_rd(1, 2);
        expect_item(K_RD, 0, 32'd0, "x4_write_discarded");
        expect_item(K_RD, 1, 32'd128, "sp_reinitialised");
        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
